// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Resolves memory stalls, multi-cycle divides, taken jumps and load-use
// hazards into fetch/ID/EX hold and bubble controls. All control outputs
// are combinational from state, divide counter and inputs.
// Optional build macro PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt counters.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        jump_req_ex,
  input  logic [31:0] jump_addr_ex,
  input  logic        load_use_id,
  input  logic        mem_busy,
  input  logic        div_start,
  input  logic        div_done,
  output logic        jump_ctl,
  output logic [31:0] jump_addr_ctl,
  output logic        hold_ctl,
  output logic        clear_ctl,
  output logic        clear_id_ctl,
  output logic        hold_ex_ctl,
  output logic        div_err,
  output logic [1:0]  o_dbg_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_SHADOW   = 2'd2
  } state_t;

  // Last counter value of a divide wait; the wait lasts at most DIV_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_div_err;
  logic             w_div_err_nxt;
  logic             w_jump;
  logic             w_hold;
  logic             w_clear;
  logic             w_clear_id;
  logic             w_hold_ex;

  // State, divide counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_div_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_err <= w_div_err_nxt;
    end
  end

  // Next state and controls; mem_busy overrides everything and freezes state
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_err_nxt = r_div_err;
    w_jump        = 1'b0;
    w_hold        = 1'b0;
    w_clear       = 1'b0;
    w_clear_id    = 1'b0;
    w_hold_ex     = 1'b0;
    if (mem_busy) begin
      w_hold    = 1'b1;
      w_hold_ex = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (jump_req_ex) begin
            // A divide issued alongside a taken jump is on the wrong path.
            w_jump      = 1'b1;
            w_clear     = 1'b1;
            w_clear_id  = 1'b1;
            w_state_nxt = ST_SHADOW;
          end else begin
            if (load_use_id) begin
              w_hold     = 1'b1;
              w_clear_id = 1'b1;
            end
            if (div_start) begin
              w_state_nxt = ST_DIV_WAIT;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_DIV_WAIT: begin
          if (div_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_hold    = 1'b1;
            w_hold_ex = 1'b1;
            if (r_cnt == CNT_LAST) begin
              w_state_nxt   = ST_RUN;
              w_div_err_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        ST_SHADOW: begin
          // Jump shadow: the instructions behind the jump are being discarded.
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Outputs forced low while reset is asserted
  assign jump_ctl      = rst_b & w_jump;
  assign jump_addr_ctl = jump_ctl ? jump_addr_ex : 32'd0;
  assign hold_ctl      = rst_b & w_hold;
  assign clear_ctl     = rst_b & w_clear;
  assign clear_id_ctl  = rst_b & w_clear_id;
  assign hold_ex_ctl   = rst_b & w_hold_ex;
  assign div_err       = rst_b & r_div_err;
  assign o_dbg_state   = r_state;

`ifdef PIPE_CTRL_PERF_EN
  // Stall and flush event counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_ctl) stall_cnt <= stall_cnt + 32'd1;
      if (jump_ctl) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with a behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_pipe_ctrl;
  localparam int TO = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        jump_req_ex = 1'b0;
  logic [31:0] jump_addr_ex = 32'd0;
  logic        load_use_id = 1'b0;
  logic        mem_busy = 1'b0;
  logic        div_start = 1'b0;
  logic        div_done = 1'b0;
  logic        jump_ctl;
  logic [31:0] jump_addr_ctl;
  logic        hold_ctl;
  logic        clear_ctl;
  logic        clear_id_ctl;
  logic        hold_ex_ctl;
  logic        div_err;
  logic [1:0]  dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .jump_req_ex(jump_req_ex), .jump_addr_ex(jump_addr_ex),
    .load_use_id(load_use_id), .mem_busy(mem_busy),
    .div_start(div_start), .div_done(div_done),
    .jump_ctl(jump_ctl), .jump_addr_ctl(jump_addr_ctl),
    .hold_ctl(hold_ctl), .clear_ctl(clear_ctl), .clear_id_ctl(clear_id_ctl),
    .hold_ex_ctl(hold_ex_ctl), .div_err(div_err), .o_dbg_state(dbg_state)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a divide in flight, how many wait cycles it has
  // spent, whether the next cycle is a jump shadow, and the sticky error.
  bit          m_div_busy = 1'b0;
  int          m_div_waits = 0;
  bit          m_in_shadow = 1'b0;
  bit          m_err = 1'b0;
  int unsigned m_stalls = 0;
  int unsigned m_flushes = 0;

  // Expected vector: {jump, addr[31:0], hold, clear, clear_id, hold_ex, div_err}
  task automatic model_step(output logic [37:0] e);
    logic        j, h, c, ci, hx, er;
    logic [31:0] a;
    j = 0; h = 0; c = 0; ci = 0; hx = 0; a = 32'd0; er = m_err;
    if (!rst_b) begin
      m_div_busy = 0; m_div_waits = 0; m_in_shadow = 0; m_err = 0;
      m_stalls = 0; m_flushes = 0;
      er = 0;
    end else begin
      if (mem_busy) begin
        h = 1; hx = 1;
      end else if (m_div_busy) begin
        if (div_done) begin
          m_div_busy = 0;
        end else begin
          h = 1; hx = 1;
          m_div_waits = m_div_waits + 1;
          if (m_div_waits == TO) begin
            m_div_busy = 0;
            m_err = 1;
          end
        end
      end else if (m_in_shadow) begin
        m_in_shadow = 0;
      end else if (jump_req_ex) begin
        j = 1; a = jump_addr_ex; c = 1; ci = 1;
        m_in_shadow = 1;
      end else begin
        if (load_use_id) begin h = 1; ci = 1; end
        if (div_start) begin m_div_busy = 1; m_div_waits = 0; end
      end
      if (h) m_stalls = m_stalls + 1;
      if (j) m_flushes = m_flushes + 1;
    end
    e = {j, a, h, c, ci, hx, er};
  endtask

  function automatic logic [37:0] dut_vec();
    return {jump_ctl, jump_addr_ctl, hold_ctl, clear_ctl, clear_id_ctl, hold_ex_ctl, div_err};
  endfunction

  // Scoreboard: expected queue fed by the model, checked on every falling edge
  logic [37:0] exp_q[$];
  always @(negedge clk) begin
    logic [37:0] e;
    logic [37:0] got_exp;
    logic [31:0] pre_stalls;
    logic [31:0] pre_flushes;
    pre_stalls  = m_stalls;
    pre_flushes = m_flushes;
    if (!rst_b) begin
      pre_stalls = 0;
      pre_flushes = 0;
    end
    model_step(e);
    exp_q.push_back(e);
    got_exp = exp_q.pop_front();
    checks++;
    if (dut_vec() !== got_exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got %h want %h", $time, dut_vec(), got_exp);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== pre_stalls || flush_cnt !== pre_flushes) begin
      errors++;
      $display("FAIL perf_cmp t=%0t got %0d/%0d want %0d/%0d", $time,
               stall_cnt, flush_cnt, pre_stalls, pre_flushes);
    end
`endif
  end

  // Literal check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input logic jr, input logic [31:0] ja, input logic lu,
                       input logic mb, input logic ds, input logic dd);
    @(posedge clk);
    #1;
    jump_req_ex = jr; jump_addr_ex = ja; load_use_id = lu;
    mem_busy = mb; div_start = ds; div_done = dd;
    #1;
  endtask

  task automatic idle();
    drive(0, 32'd0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state, with mem_busy asserted to show outputs stay low
    mem_busy = 1'b1;
    #2;
    chk("rst_hold", {31'd0, hold_ctl}, 32'd0);
    chk("rst_all", {26'd0, dut_vec() != 38'd0}, 32'd0);
    repeat (2) @(posedge clk);
    mem_busy = 1'b0;
    #3 rst_b = 1'b1;

    // Jump then shadow with load_use ignored
    drive(1, 32'h0000_0100, 0, 0, 0, 0);
    chk("jmp_ctl", {31'd0, jump_ctl}, 32'd1);
    chk("jmp_addr", jump_addr_ctl, 32'h100);
    chk("jmp_clr", {30'd0, clear_ctl, clear_id_ctl}, 32'd3);
    drive(1, 32'h0000_0200, 1, 0, 0, 0);
    chk("shadow_out", {26'd0, dut_vec() != 38'd0}, 32'd0);
    idle();

    // Divide completing after 5 wait cycles
    drive(0, 32'd0, 0, 0, 1, 0);
    chk("div_issue_hold", {31'd0, hold_ctl}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("div_wait_hold", {30'd0, hold_ctl, hold_ex_ctl}, 32'd3);
    end
    drive(0, 32'd0, 0, 0, 0, 1);
    chk("div_done_rel", {30'd0, hold_ctl, hold_ex_ctl}, 32'd0);
    idle();
    chk("div_no_err", {31'd0, div_err}, 32'd0);

    // Load-use for exactly one cycle
    drive(0, 32'd0, 1, 0, 0, 0);
    chk("lu_ctl", {29'd0, hold_ctl, clear_id_ctl, hold_ex_ctl}, 32'd6);
    idle();
    chk("lu_end", {31'd0, hold_ctl}, 32'd0);

    // Memory stall holding back a jump
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_0040, 0, 1, 0, 0);
      chk("mem_hold", {29'd0, hold_ctl, hold_ex_ctl, jump_ctl}, 32'd6);
      chk("mem_addr0", jump_addr_ctl, 32'd0);
    end
    drive(1, 32'h0000_0040, 0, 0, 0, 0);
    chk("mem_jmp_addr", jump_addr_ctl, 32'h40);
    idle();
    idle();

    // Jump and div_start together: divide dropped
    drive(1, 32'hdead_beec, 0, 0, 1, 0);
    chk("jd_jump", {31'd0, jump_ctl}, 32'd1);
    idle();
    idle();
    chk("jd_no_div", {31'd0, hold_ctl}, 32'd0);

    // mem_busy inside a divide freezes it and masks div_done
    drive(0, 32'd0, 0, 0, 1, 0);
    idle();
    drive(0, 32'd0, 0, 1, 0, 1);
    drive(0, 32'd0, 0, 1, 0, 1);
    drive(0, 32'd0, 0, 0, 0, 1);
    chk("div_mb_rel", {31'd0, hold_ctl}, 32'd0);
    idle();

    // Timeout: 8 held cycles then sticky error
    drive(0, 32'd0, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) begin
      idle();
      chk("to_hold", {30'd0, hold_ctl, hold_ex_ctl}, 32'd3);
    end
    idle();
    chk("to_rel", {30'd0, hold_ctl, div_err}, 32'd1);
    drive(1, 32'h0000_0800, 0, 0, 0, 0);
    idle();
    idle();
    chk("to_sticky", {31'd0, div_err}, 32'd1);

    // Asynchronous reset in the third divide wait cycle
    drive(0, 32'd0, 0, 0, 1, 0);
    idle();
    idle();
    idle();
    chk("rm_pre_hold", {31'd0, hold_ctl}, 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rm_out_zero", {26'd0, dut_vec() != 38'd0}, 32'd0);
    chk("rm_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #4 rst_b = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
    chk("rm_stall_cnt", stall_cnt, 32'd0);
`endif
    idle();
    chk("rm_run_hold", {30'd0, hold_ctl, div_err}, 32'd0);
    idle();

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 64: maximum DIV_WAIT cycles before forced exit.
REQ-002 SHALL have parameter CNT_W, default 8: width of the divide-wait counter; DIV_TIMEOUT SHALL be at most 2^CNT_W-1.
REQ-003 SHALL have input clk, 1 bit: clock, rising edge.
REQ-004 SHALL have input rst_b, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input jump_req_ex, 1 bit: EX-stage taken branch/jump.
REQ-006 SHALL have input jump_addr_ex, 32 bits: EX-stage target address.
REQ-007 SHALL have input load_use_id, 1 bit: ID-stage load-use hazard.
REQ-008 SHALL have input mem_busy, 1 bit: data memory not ready.
REQ-009 SHALL have input div_start, 1 bit: EX issues a multi-cycle divide.
REQ-010 SHALL have input div_done, 1 bit: divider result valid.
REQ-011 SHALL have output jump_ctl, 1 bit: redirect fetch.
REQ-012 SHALL have output jump_addr_ctl, 32 bits: fetch redirect address.
REQ-013 SHALL have output hold_ctl, 1 bit: freeze fetch and ID.
REQ-014 SHALL have output clear_ctl, 1 bit: bubble fetch output.
REQ-015 SHALL have output clear_id_ctl, 1 bit: bubble ID-to-EX register.
REQ-016 SHALL have output hold_ex_ctl, 1 bit: freeze EX and later stages.
REQ-017 SHALL have output div_err, 1 bit: sticky divide-timeout flag.

Function
REQ-018 SHALL implement FSM states RUN, DIV_WAIT and SHADOW; all outputs SHALL be combinational from state, counter and inputs, with no added latency.
REQ-019 Priority SHALL be mem_busy > DIV_WAIT > jump_req_ex > load_use_id.
REQ-020 mem_busy=1 in any state SHALL drive hold_ctl=1 and hold_ex_ctl=1 and force jump_ctl, clear_ctl and clear_id_ctl to 0; state, counter and div_err SHALL be frozen.
REQ-021 RUN with div_start=1 and mem_busy=0 SHALL go to DIV_WAIT and load the counter with 0.
REQ-022 DIV_WAIT SHALL drive hold_ctl=1 and hold_ex_ctl=1 and increment the counter each cycle while div_done=0.
REQ-023 div_done=1 in DIV_WAIT SHALL release both holds in the same cycle; the next state SHALL be RUN.
REQ-024 If the counter reaches DIV_TIMEOUT-1 without div_done, the FSM SHALL release both holds, set div_err=1 (sticky until reset) and go to RUN.
REQ-025 RUN with jump_req_ex=1 and no higher-priority event SHALL drive jump_ctl=1, jump_addr_ctl=jump_addr_ex, clear_ctl=1 and clear_id_ctl=1 that cycle; the next state SHALL be SHADOW.
REQ-026 SHADOW SHALL last exactly one non-mem_busy cycle: load_use_id and jump_req_ex ignored, all outputs 0, then RUN.
REQ-027 RUN with load_use_id=1 and no higher-priority event SHALL drive hold_ctl=1 and clear_id_ctl=1 with hold_ex_ctl=0, for one cycle per asserted cycle.
REQ-028 jump_req_ex and div_start in the same RUN cycle: the jump SHALL be serviced and div_start ignored, because the divide is on the wrong path.
REQ-029 jump_addr_ctl SHALL be 32'd0 whenever jump_ctl=0.

Reset
REQ-030 rst_b=0 SHALL asynchronously force state RUN, counter 0, div_err 0 and every output 0, including mid-DIV_WAIT.
REQ-031 The first rising clk edge after rst_b deasserts SHALL evaluate from RUN.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_EN SHALL, when defined, add 32-bit outputs stall_cnt and flush_cnt, both 0 at reset.
REQ-033 With PIPE_CTRL_PERF_EN defined, stall_cnt SHALL increment each cycle hold_ctl=1, and flush_cnt SHALL increment each cycle jump_ctl=1; both SHALL wrap modulo 2^32.
REQ-034 Without PIPE_CTRL_PERF_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Jump: RUN, jump_req_ex=1, jump_addr_ex=0x0000_0100 -> same cycle jump_ctl=1, jump_addr_ctl=0x100, clear_ctl=1, clear_id_ctl=1; next cycle load_use_id=1 ignored, all outputs 0.
REQ-036 Divide: div_start pulse, div_done asserted 5 cycles later -> hold_ctl=hold_ex_ctl=1 for 5 cycles, released in the div_done cycle, div_err=0.
REQ-037 Timeout: div_start, div_done never asserted, DIV_TIMEOUT=8 -> holds for 8 cycles, then div_err=1 and RUN; div_err stays 1 until rst_b=0.
REQ-038 Memory stall: mem_busy=1 for 3 cycles with jump_req_ex=1 -> 3 cycles of hold_ctl=hold_ex_ctl=1 and jump_ctl=0, then jump issued in the 4th cycle.
REQ-039 Load-use: load_use_id=1 for 1 cycle -> hold_ctl=1, clear_id_ctl=1, hold_ex_ctl=0 for exactly one cycle.
REQ-040 Reset mid-divide: rst_b=0 asynchronously in cycle 3 of DIV_WAIT -> all outputs 0 immediately; with PIPE_CTRL_PERF_EN defined, stall_cnt=0 after release.
